// File: rtl/tilemap_writer_if.sv
// Bundle of the CPU register bus and the tilemap RAM write port for tilemap_writer.
// The engine side (master) drives RAM requests, RAM writes, CPU read data and busy.
// The environment side (slave) drives CPU accesses and the arbiter grant.
interface tilemap_writer_if #(
  parameter int TILEMAP_RAM_WIDTH = 10
);
  // CPU register access
  logic [2:0]                   addr;
  logic [7:0]                   data_in;
  logic                         write;
  logic [7:0]                   data_out;

  // Tilemap RAM port, shared through a req/gnt arbiter
  logic                         ram_req;
  logic                         ram_gnt;
  logic [TILEMAP_RAM_WIDTH-1:0] tilemapram_addr;
  logic [7:0]                   tilemapram_data_in;
  logic                         tilemapram_wr;

  // Command in progress
  logic                         busy;

  modport master (
    input  addr, data_in, write, ram_gnt,
    output data_out, ram_req, tilemapram_addr, tilemapram_data_in, tilemapram_wr, busy
  );

  modport slave (
    output addr, data_in, write, ram_gnt,
    input  data_out, ram_req, tilemapram_addr, tilemapram_data_in, tilemapram_wr, busy
  );
endinterface

// File: rtl/tilemap_writer.sv
// Command-driven rectangle fill / clear engine writing tile indices into tilemap RAM.
// Latency: command write -> REQ next cycle; one cell written per granted cycle in WRITE.
// Backpressure: ram_gnt low holds the cursor with ram_req kept high; RAM writes are gated by grant.
module tilemap_writer #(
  parameter int         TILEMAP_RAM_WIDTH = 10,
  parameter logic [4:0] TILEMAP_CELLS_X   = 5'd22,
  parameter logic [4:0] TILEMAP_CELLS_Y   = 5'd17,
  parameter logic [7:0] CLEAR_TILE        = 8'd0
) (
  input  logic              clk,
  input  logic              reset,
  tilemap_writer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // CPU-visible registers
  logic [4:0] reg_x0;
  logic [4:0] reg_y0;
  logic [4:0] reg_w;
  logic [4:0] reg_h;
  logic [7:0] reg_tile;
  logic [1:0] reg_cmd;
  logic       overrun;
  logic       busy_q;

  // Working copy of the running command and its cursor
  logic [4:0] wx0;
  logic [4:0] x_last;
  logic [4:0] y_last;
  logic [4:0] cx;
  logic [4:0] cy;
  logic [TILEMAP_RAM_WIDTH-1:0] ram_addr_q;
  logic [7:0] ram_data_q;

  // Decode of the current CPU access
  logic       cmd_write;
  logic       cmd_valid;
  logic       cmd_clear;
  logic       start;

  // Command source values before clipping (CLEAR overrides the registers)
  logic [4:0] src_x0;
  logic [4:0] src_y0;
  logic [4:0] src_w;
  logic [4:0] src_h;
  logic [7:0] src_tile;

  // Clipping results
  logic [4:0] room_x;
  logic [4:0] room_y;
  logic [4:0] w_eff;
  logic [4:0] h_eff;
  logic [4:0] x_last_nxt;
  logic [4:0] y_last_nxt;
  logic       empty_cmd;

  // Cursor stepping
  logic       last_cell;
  logic [4:0] cx_nxt;
  logic [4:0] cy_nxt;

  // FSM outputs
  logic       ram_req;
  logic       ram_wr;

  assign cmd_write = bus.write && (bus.addr == 3'd5);
  assign cmd_valid = (bus.data_in == 8'd1) || (bus.data_in == 8'd2);
  assign cmd_clear = (bus.data_in == 8'd2);
  assign start     = (state == S_IDLE) && cmd_write && cmd_valid;

  assign src_x0   = cmd_clear ? 5'd0            : reg_x0;
  assign src_y0   = cmd_clear ? 5'd0            : reg_y0;
  assign src_w    = cmd_clear ? TILEMAP_CELLS_X : reg_w;
  assign src_h    = cmd_clear ? TILEMAP_CELLS_Y : reg_h;
  assign src_tile = cmd_clear ? CLEAR_TILE      : reg_tile;

  // Room left to the visible edge; only meaningful when the origin lies inside the map,
  // which the empty check guarantees before these values are used.
  assign room_x     = TILEMAP_CELLS_X - src_x0;
  assign room_y     = TILEMAP_CELLS_Y - src_y0;
  assign w_eff      = (src_w < room_x) ? src_w : room_x;
  assign h_eff      = (src_h < room_y) ? src_h : room_y;
  assign x_last_nxt = src_x0 + w_eff - 5'd1;
  assign y_last_nxt = src_y0 + h_eff - 5'd1;
  assign empty_cmd  = (src_x0 >= TILEMAP_CELLS_X) || (src_y0 >= TILEMAP_CELLS_Y) ||
                      (src_w == 5'd0) || (src_h == 5'd0);

  // Row-major walk: step x, wrap to the rectangle's left edge and move down a row.
  assign last_cell = (cx == x_last) && (cy == y_last);
  assign cx_nxt    = (cx == x_last) ? wx0 : cx + 5'd1;
  assign cy_nxt    = (cx == x_last) ? cy + 5'd1 : cy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and RAM handshake; the write strobe is gated by grant and by reset so
  // that no write slips out in the cycle a reset or a grant drop arrives.
  always_comb begin
    state_nxt = state;
    ram_req   = 1'b0;
    ram_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = empty_cmd ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        ram_req = 1'b1;
        if (bus.ram_gnt) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        ram_req = 1'b1;
        ram_wr  = bus.ram_gnt && !reset;
        if (bus.ram_gnt && last_cell) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // CPU register file, command register and overrun flag. A command write outside IDLE
  // (including the DONE cycle) is dropped and flagged as an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_x0   <= 5'd0;
      reg_y0   <= 5'd0;
      reg_w    <= 5'd0;
      reg_h    <= 5'd0;
      reg_tile <= 8'd0;
      reg_cmd  <= 2'd0;
      overrun  <= 1'b0;
    end else begin
      if (state == S_DONE) begin
        reg_cmd <= 2'd0;
      end
      if (bus.write) begin
        case (bus.addr)
          3'd0: reg_x0   <= bus.data_in[4:0];
          3'd1: reg_y0   <= bus.data_in[4:0];
          3'd2: reg_w    <= bus.data_in[4:0];
          3'd3: reg_h    <= bus.data_in[4:0];
          3'd4: reg_tile <= bus.data_in;
          3'd5: begin
            if (state != S_IDLE) begin
              overrun <= 1'b1;
            end else if (cmd_valid) begin
              reg_cmd <= bus.data_in[1:0];
            end
          end
          3'd6: overrun <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Command engine: latch the clipped rectangle at start, step the cursor on each
  // granted write, and keep the RAM address/data registered one step ahead.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= 1'b0;
      wx0        <= 5'd0;
      x_last     <= 5'd0;
      y_last     <= 5'd0;
      cx         <= 5'd0;
      cy         <= 5'd0;
      ram_addr_q <= '0;
      ram_data_q <= 8'd0;
    end else begin
      if (start && !empty_cmd) begin
        busy_q     <= 1'b1;
        wx0        <= src_x0;
        x_last     <= x_last_nxt;
        y_last     <= y_last_nxt;
        cx         <= src_x0;
        cy         <= src_y0;
        ram_addr_q <= TILEMAP_RAM_WIDTH'({src_y0, src_x0});
        ram_data_q <= src_tile;
      end else if (ram_wr && !last_cell) begin
        cx         <= cx_nxt;
        cy         <= cy_nxt;
        ram_addr_q <= TILEMAP_RAM_WIDTH'({cy_nxt, cx_nxt});
      end
      if (state == S_DONE) begin
        busy_q <= 1'b0;
      end
    end
  end

  // CPU read mux, unused upper bits return zero
  always_comb begin
    bus.data_out = 8'd0;
    case (bus.addr)
      3'd0:    bus.data_out = {3'd0, reg_x0};
      3'd1:    bus.data_out = {3'd0, reg_y0};
      3'd2:    bus.data_out = {3'd0, reg_w};
      3'd3:    bus.data_out = {3'd0, reg_h};
      3'd4:    bus.data_out = reg_tile;
      3'd5:    bus.data_out = {6'd0, reg_cmd};
      3'd6:    bus.data_out = {6'd0, overrun, busy_q};
      default: bus.data_out = 8'd0;
    endcase
  end

  assign bus.ram_req            = ram_req;
  assign bus.tilemapram_wr      = ram_wr;
  assign bus.tilemapram_addr    = ram_addr_q;
  assign bus.tilemapram_data_in = ram_data_q;
  assign bus.busy               = busy_q;

endmodule

// File: tb/tb_tilemap_writer.sv
// Directed bench for tilemap_writer: fills, clipping, CLEAR, grant gaps, overrun, reset abort.
// Every RAM write is logged on the falling edge and compared against hand-computed values.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_tilemap_writer;

  logic clk;
  logic reset;

  tilemap_writer_if #(.TILEMAP_RAM_WIDTH(10)) bus ();

  tilemap_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] wa[$];
  logic [7:0] wd[$];
  int         busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every RAM write and every busy cycle
  always @(negedge clk) begin
    if (bus.tilemapram_wr === 1'b1) begin
      wa.push_back(bus.tilemapram_addr);
      wd.push_back(bus.tilemapram_data_in);
    end
    if (bus.busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.addr    = a;
    bus.data_in = d;
    bus.write   = 1'b1;
    @(posedge clk); #1;
    bus.write   = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    bus.addr = a;
    @(negedge clk);
    d = bus.data_out;
  endtask

  task automatic program_rect(input logic [7:0] x0, input logic [7:0] y0,
                              input logic [7:0] w, input logic [7:0] h,
                              input logic [7:0] tile);
    cpu_write(3'd0, x0);
    cpu_write(3'd1, y0);
    cpu_write(3'd2, w);
    cpu_write(3'd3, h);
    cpu_write(3'd4, tile);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finish"}, int'(n < budget), 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [7:0] d;
    int base;
    int b0;
    int n;
    int bad;
    int gap_wr;
    int gap_req_lo;

    reset       = 1'b1;
    bus.addr    = 3'd0;
    bus.data_in = 8'd0;
    bus.write   = 1'b0;
    bus.ram_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_req",  int'(bus.ram_req), 0);
    check("rst_wr",   int'(bus.tilemapram_wr), 0);
    check("rst_addr", int'(bus.tilemapram_addr), 0);
    check("rst_data", int'(bus.tilemapram_data_in), 0);
    for (int r = 0; r < 8; r++) begin
      cpu_read(3'(r), d);
      check($sformatf("rst_reg%0d", r), int'(d), 0);
    end

    // Register masking, reg 7, ignored command values
    cpu_write(3'd0, 8'hFF);
    cpu_read(3'd0, d);
    check("reg0_mask", int'(d), 'h1F);
    cpu_write(3'd4, 8'hC3);
    cpu_read(3'd4, d);
    check("reg4_full", int'(d), 'hC3);
    cpu_write(3'd7, 8'h5A);
    cpu_read(3'd7, d);
    check("reg7_zero", int'(d), 0);
    cpu_write(3'd5, 8'd3);
    cpu_read(3'd5, d);
    check("cmd3_ignored", int'(d), 0);
    check("cmd3_busy", int'(bus.busy), 0);
    cpu_write(3'd5, 8'd0);
    cpu_read(3'd6, d);
    check("cmd0_status", int'(d), 0);

    // 2x2 FILL at (3,4)
    program_rect(8'd3, 8'd4, 8'd2, 8'd2, 8'h2A);
    base = wa.size();
    b0   = busy_cnt;
    cpu_write(3'd5, 8'd1);
    wait_idle("fill2x2", 100);
    check("fill2x2_count", wa.size() - base, 4);
    if (wa.size() >= base + 4) begin
      check("fill2x2_a0", int'(wa[base]),     'h083);
      check("fill2x2_a1", int'(wa[base + 1]), 'h084);
      check("fill2x2_a2", int'(wa[base + 2]), 'h0A3);
      check("fill2x2_a3", int'(wa[base + 3]), 'h0A4);
      check("fill2x2_d3", int'(wd[base + 3]), 'h2A);
    end
    check("fill2x2_busy_cycles", busy_cnt - b0, 6);
    check("fill2x2_busy_end", int'(bus.busy), 0);
    cpu_read(3'd5, d);
    check("fill2x2_cmd_clr", int'(d), 0);

    // Clipped at the bottom-right corner
    program_rect(8'd20, 8'd16, 8'd5, 8'd3, 8'h11);
    base = wa.size();
    cpu_write(3'd5, 8'd1);
    wait_idle("clip", 100);
    check("clip_count", wa.size() - base, 2);
    if (wa.size() >= base + 2) begin
      check("clip_a0", int'(wa[base]),     'h214);
      check("clip_a1", int'(wa[base + 1]), 'h215);
    end

    // Origin outside the map: empty command, no writes, no busy
    program_rect(8'd22, 8'd0, 8'd3, 8'd3, 8'h11);
    base = wa.size();
    cpu_write(3'd5, 8'd1);
    check("empty_busy", int'(bus.busy), 0);
    repeat (4) @(posedge clk);
    check("empty_count", wa.size() - base, 0);
    cpu_read(3'd5, d);
    check("empty_cmd_clr", int'(d), 0);
    cpu_read(3'd6, d);
    check("empty_status", int'(d), 0);

    // CLEAR
    base = wa.size();
    b0   = busy_cnt;
    cpu_write(3'd5, 8'd2);
    wait_idle("clear", 1000);
    check("clear_count", wa.size() - base, 374);
    check("clear_busy_cycles", busy_cnt - b0, 376);
    if (wa.size() >= base + 374) begin
      bad = 0;
      n   = 0;
      for (int y = 0; y < 17; y++) begin
        for (int x = 0; x < 22; x++) begin
          if (wa[base + n] !== 10'((y << 5) | x) || wd[base + n] !== 8'd0) bad++;
          n++;
        end
      end
      check("clear_sequence_bad", bad, 0);
      check("clear_first", int'(wa[base]), 'h000);
      check("clear_last",  int'(wa[base + 373]), 'h215);
    end

    // FILL 4x1 with a grant gap after the second write
    program_rect(8'd0, 8'd0, 8'd4, 8'd1, 8'h55);
    base = wa.size();
    cpu_write(3'd5, 8'd1);
    n = 0;
    while (wa.size() < base + 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("gap_reach2", int'(n < 50), 1);
    bus.ram_gnt = 1'b0;
    gap_wr      = 0;
    gap_req_lo  = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.tilemapram_wr !== 1'b0) gap_wr++;
      if (bus.ram_req !== 1'b1) gap_req_lo++;
    end
    check("gap_no_wr", gap_wr, 0);
    check("gap_req_held", gap_req_lo, 0);
    @(posedge clk); #1;
    bus.ram_gnt = 1'b1;
    wait_idle("gap", 100);
    check("gap_count", wa.size() - base, 4);
    if (wa.size() >= base + 4) begin
      check("gap_a1", int'(wa[base + 1]), 'h001);
      check("gap_a2", int'(wa[base + 2]), 'h002);
      check("gap_a3", int'(wa[base + 3]), 'h003);
    end

    // Overrun while busy (grant held off to keep the command running)
    program_rect(8'd0, 8'd0, 8'd4, 8'd2, 8'h66);
    bus.ram_gnt = 1'b0;
    base = wa.size();
    cpu_write(3'd5, 8'd1);
    cpu_write(3'd5, 8'd2);
    cpu_read(3'd6, d);
    check("ovr_status", int'(d), 'h03);
    cpu_read(3'd5, d);
    check("ovr_cmd_kept", int'(d), 1);
    cpu_write(3'd6, 8'd0);
    cpu_read(3'd6, d);
    check("ovr_cleared_busy", int'(d), 'h01);
    @(posedge clk); #1;
    bus.ram_gnt = 1'b1;
    wait_idle("ovr", 100);
    cpu_read(3'd6, d);
    check("ovr_status_done", int'(d), 'h00);
    check("ovr_count", wa.size() - base, 8);
    if (wa.size() >= base + 8) begin
      check("ovr_data", int'(wd[base + 7]), 'h66);
    end

    // Reset in the middle of a full-map FILL
    program_rect(8'd0, 8'd0, 8'd22, 8'd17, 8'h77);
    base = wa.size();
    cpu_write(3'd5, 8'd1);
    n = 0;
    while (wa.size() < base + 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstmid_reach3", int'(n < 50), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_wr",   int'(bus.tilemapram_wr), 0);
    check("rstmid_req",  int'(bus.ram_req), 0);
    check("rstmid_busy", int'(bus.busy), 0);
    for (int r = 0; r < 7; r++) begin
      cpu_read(3'(r), d);
      check($sformatf("rstmid_reg%0d", r), int'(d), 0);
    end
    repeat (10) @(posedge clk);
    check("rstmid_count", wa.size() - base, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tilemap_writer.md
Name: tilemap_writer

Overview:
- Command-driven writer engine for the tilemap index RAM.
- CPU programs a rectangle (origin, size, tile index) or a clear command; the block streams one index byte per cycle into tilemap RAM.
- Sits beside the tilemap renderer. It shares the RAM address/write port through a req/gnt arbiter and is the write side for the renderer's index lookups.

Parameters:
- TILEMAP_RAM_WIDTH, 10, tilemap RAM address width; address = {y[4:0], x[4:0]}.
- TILEMAP_CELLS_X, 5'd22, visible cell columns.
- TILEMAP_CELLS_Y, 5'd17, visible cell rows.
- CLEAR_TILE, 8'd0, index value written by the CLEAR command.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- addr  in  3  CPU register select.
- data_in  in  8  CPU write data.
- write  in  1  CPU write strobe, one cycle per write.
- data_out  out  8  CPU read data, combinational from addr.
- ram_req  out  1  request for the tilemap RAM port.
- ram_gnt  in  1  arbiter grant; may drop at any cycle.
- tilemapram_addr  out  TILEMAP_RAM_WIDTH  RAM write address.
- tilemapram_data_in  out  8  RAM write data.
- tilemapram_wr  out  1  RAM write enable.
- busy  out  1  command in progress.

Behaviour:
- Register map:
  - 0 = X0[4:0]; 1 = Y0[4:0]; 2 = W[4:0]; 3 = H[4:0]; 4 = tile index.
  - 5 = command: 0 IDLE, 1 FILL, 2 CLEAR; other values are ignored.
  - 6 = status: bit0 busy, bit1 overrun. Any write to reg 6 clears overrun.
  - 7 reads 0.
  - Unused upper bits of regs 0-3 read back 0.
- Reset values:
  - All registers 0.
  - busy=0, ram_req=0, tilemapram_wr=0, tilemapram_addr=0, tilemapram_data_in=0.
  - State IDLE.
  - Reset mid-operation aborts immediately, with no further writes.
- States: IDLE, REQ, WRITE, DONE.
- IDLE:
  - A write of 1 or 2 to reg 5 latches the working copy: x0, y0, w, h, tile.
  - CLEAR uses x0=0, y0=0, w=CELLS_X, h=CELLS_Y, tile=CLEAR_TILE.
  - Clipping at latch time:
    - w_eff = min(w, CELLS_X - x0); h_eff likewise on Y.
    - x0 >= CELLS_X, y0 >= CELLS_Y, w=0 or h=0 all mean an empty command.
    - No wrap-around at any edge.
  - Empty command goes to DONE with zero writes.
  - Otherwise busy=1 on the next cycle, cursor (cx, cy) = (x0, y0), go to REQ.
- REQ:
  - ram_req=1; tilemapram_addr={cy,cx}; tilemapram_data_in=tile.
  - Go to WRITE when ram_gnt=1.
- WRITE:
  - tilemapram_wr = ram_gnt (combinational gate, so a write never occurs without grant). Addr and data are registered.
  - Each cycle with wr=1, advance the cursor: cx+1. At cx = x0 + w_eff - 1, cx = x0 and cy+1. Addr is updated for the next cycle.
  - While ram_gnt=0 the cursor holds and ram_req stays 1.
  - The cycle writing the last cell (x0 + w_eff - 1, y0 + h_eff - 1) leads to DONE.
- DONE (1 cycle):
  - ram_req=0, wr=0, reg 5 cleared to 0, busy=0; go to IDLE.
- Write throughput is 1 cell per granted cycle. A full CLEAR with constant grant is 374 writes; busy stays high for 374 + 2 cycles.
- CPU interaction while busy:
  - A write to reg 5 is ignored and sets overrun=1.
  - Writes to regs 0-4 are stored but do not affect the running command.
- A write to reg 5 in the same cycle as DONE counts as busy: it is ignored and sets overrun.
- Writing 0 to reg 5 while idle has no effect.
- busy mirrors status bit0.

Test Plan:
- X0=3, Y0=4, W=2, H=2, tile=0x2A, FILL, gnt tied 1 -> exactly 4 writes of 0x2A at addresses 0x083, 0x084, 0x0A3, 0x0A4 in that order; then busy=0 and reg 5 reads 0.
- X0=20, Y0=16, W=5, H=3, FILL, gnt=1 -> only 2 writes, at 0x214 and 0x215; no address with x>21 or y>16.
- CLEAR with CLEAR_TILE=0, gnt=1 -> 374 writes of 0x00, from addr 0x000 to 0x215, with none to x in 22..31; busy high for 376 cycles.
- FILL 4x1 at (0,0), gnt low for 5 cycles after the 2nd write -> wr=0 throughout the gap, then writes resume at 0x002 and 0x003; total 4 writes.
- FILL running, CPU writes 2 to reg 5 -> command ignored, status reads 0x03; writing reg 6 -> 0x01 while busy, 0x00 after completion.
- Assert reset after 3 writes of a 22x17 FILL -> next cycle wr=0, req=0, busy=0, all registers 0; no further writes.
